// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the elastic pipeline register
package pipe_pkg;

  // Fill level of the stage: nothing held, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } elastic_state_t;

  // Width of the occupancy output (counts 0..2).
  localparam int OCC_W = 2;

endpackage

// File: rtl/d_ff_en_w.sv
// rtl/d_ff_en_w.sv - WIDTH-bit enabled flop bank with async active-low reset
module d_ff_en_w #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic bit_q;
    logic bit_d;

    // Next value: load when enabled, otherwise hold.
    always_comb begin
      bit_d = en ? d[i] : bit_q;
    end

    // Per-bit storage, reset to the matching bit of RESET_VAL.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bit_q <= RESET_VAL[i];
      end else begin
        bit_q <= bit_d;
      end
    end

    assign q[i] = bit_q;
  end

endmodule

// File: rtl/pipe_reg_elastic.sv
// rtl/pipe_reg_elastic.sv - elastic pipeline register with skid buffer, flush and transfer counter
module pipe_reg_elastic
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic [OCC_W-1:0]   occupancy,
  output logic [COUNT_W-1:0] xfer_count
);

  elastic_state_t     state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic             accept;
  logic             drain;
  logic             main_en;
  logic             skid_en;
  logic             main_from_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // Handshake outputs come straight from the state register, so neither
  // in_ready nor out_valid has a combinational path from any input.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Next state and data-register enables; flush squashes to EMPTY and
  // freezes both data registers while still letting the drain complete.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_en = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_en = 1'b1;
        end else if (accept) begin
          skid_en = 1'b1;
          state_d = TWO;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  // Main register is refilled from the skid when it drains, else from upstream.
  always_comb begin
    main_d = main_from_skid ? skid_q : in_data;
  end

  // Transfer counter wraps naturally at 2^COUNT_W and ignores flush.
  always_comb begin
    count_d = drain ? (count_q + COUNT_W'(1)) : count_q;
  end

  // Occupancy decoded from state.
  always_comb begin
    case (state_q)
      ONE:     occupancy = OCC_W'(1);
      TWO:     occupancy = OCC_W'(2);
      default: occupancy = OCC_W'(0);
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign xfer_count = count_q;

  d_ff_en_w #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk   (clk),
    .rst_n (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  d_ff_en_w #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk   (clk),
    .rst_n (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: doc/pipe_reg_elastic.md
# pipe_reg_elastic

Parametrised elastic pipeline register: a WIDTH-bit stage with valid/ready handshakes on both sides, a one-entry skid buffer so `in_ready` is driven only from registers, a synchronous flush, and a wrapping transfer counter. It replaces fixed-width 64-bit flop banks between CPU pipeline stages wherever back-pressure or squash is needed. Full throughput is one transfer per cycle; latency is one cycle.

## Interface
- `WIDTH`, 64: payload width in bits.
- `RESET_VAL`, '0: WIDTH-bit value loaded into both data registers on reset.
- `COUNT_W`, 16: width of the transfer counter.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 = reset asserted.
- `flush`  in  1  synchronous squash; discards all held entries.
- `in_valid`  in  1  upstream has data.
- `in_data`  in  WIDTH  upstream payload.
- `in_ready`  out  1  stage can accept; registered, from state only.
- `out_valid`  out  1  `out_data` holds a valid entry.
- `out_data`  out  WIDTH  head entry (main register).
- `out_ready`  in  1  downstream accepts.
- `occupancy`  out  2  number of held entries, 0..2.
- `xfer_count`  out  COUNT_W  number of downstream transfers, wrapping.

## Operation
- `accept` = `in_valid & in_ready`; `drain` = `out_valid & out_ready`.
- States are EMPTY, ONE (main full) and TWO (main + skid full).
- `out_valid` = (state != EMPTY). `in_ready` = (state != TWO). `occupancy` is 0/1/2 per state. `out_data` = main.
- EMPTY: on accept, main <= in_data and go to ONE.
- ONE:
  - accept & drain: main <= in_data, stay in ONE.
  - accept & !drain: skid <= in_data, go to TWO.
  - !accept & drain: go to EMPTY.
  - Otherwise hold.
- TWO: on drain, main <= skid and go to ONE. No accept is possible in TWO.
- Order is preserved at all times; no entry is duplicated or dropped except by flush or reset.
- `flush` = 1 overrides all other inputs:
  - Next state is EMPTY.
  - An accept in that cycle is discarded.
  - A drain in that cycle still completes and is still counted.
  - Data registers hold their values; they are not cleared.
- `xfer_count` increments by 1 on every drain, modulo 2^COUNT_W. `flush` does not clear it.
- Reset (`reset` = 0), applied asynchronously and at any time, including mid-transfer:
  - state = EMPTY
  - main = skid = RESET_VAL
  - `xfer_count` = 0
  - Resulting outputs: `out_valid` = 0, `occupancy` = 0, `in_ready` = 1, `out_data` = RESET_VAL.
  - Handshakes presented while reset is asserted have no effect.

## Timing
- Input-to-output latency: data accepted at edge N is visible on `out_data` with `out_valid` = 1 after edge N.
- Steady state: with `in_valid` = `out_ready` = 1, one transfer per cycle with no bubbles.
- Back-pressure:
  - `out_ready` low for one cycle fills the skid; `in_ready` falls after that edge.
  - It rises one edge after the next drain.
- `in_ready` and `out_valid` never depend combinationally on `in_valid`, `out_ready` or `flush`.
- `flush` takes effect at the next rising edge; `out_valid` = 0 immediately after that edge.
- Reset release is synchronous to `clk` upstream; the first accept is legal on the first edge with `reset` = 1.

## Structure
- Package `pipe_pkg`: enum `elastic_state_t` {EMPTY, ONE, TWO} (2-bit encoding) and the `occupancy` width constant.
- Sub-module `d_ff_en_w`: a WIDTH-parametrised enabled flop bank with asynchronous active-low reset to RESET_VAL, built from a generate loop. Instantiated twice, for main and skid.
- The FSM, enables, mux of in_data/skid into main, and the counter stay in `pipe_reg_elastic`.

## Test plan
- Reset mid-stream:
  - Stimulus: fill to TWO with 0x1B, 0x863, then assert `reset` = 0 between edges.
  - Required: outputs go immediately to `out_valid` = 0, `occupancy` = 0, `out_data` = RESET_VAL, `xfer_count` = 0.
- Streaming:
  - Stimulus: 8 back-to-back values 0..7 with `out_ready` held at 1.
  - Required: outputs 0..7 in order, one per cycle starting one cycle after the first accept; `xfer_count` = 8.
- Skid fill:
  - Stimulus: send 0x1E, 0x2A with `out_ready` = 0.
  - Required: `occupancy` = 2, `in_ready` = 0, `out_data` = 0x1E.
  - Then raise `out_ready`: outputs 0x1E then 0x2A, `in_ready` returns to 1.
- Flush collisions:
  - Stimulus: in state TWO, assert `flush` together with `out_ready` = 1.
  - Required: the head drains and is counted (`xfer_count` + 1), next state is EMPTY, the skid entry is never output.
  - Stimulus: `flush` together with an accept while EMPTY.
  - Required: still EMPTY afterwards.
- Counter wrap:
  - Stimulus: `COUNT_W` = 4, 17 drains.
  - Required: `xfer_count` = 1.
- Random:
  - Stimulus: random `in_valid`/`out_ready` over 2000 cycles, checked against a scoreboard queue.
  - Required: no loss, duplication or reordering.
